// File: rtl/meas_sched.sv
// meas_sched -- measurement-window scheduler for the statistics stage.
//
// Software programs WINDOW / RTT / PROTO over the localbus and writes go.
// The block then clears the statistics counters (CLEAR), holds sent_start
// for WINDOW cycles (RUN), pulses sent_end and waits RTT drain cycles
// (DRAIN), and captures the 64-bit bit/packet counters (SNAP).
//
// Optional feature macro: MEAS_SCHED_PERIODIC_EN
//   defined   -> CTRL bit3 'periodic' and register 0x24 GAP exist; after SNAP
//                the block idles GAP cycles and restarts automatically.
//   undefined -> single-shot only; CTRL bit3 and GAP read 0.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cfg_cs_n, cfg_rw      localbus select (active-low), 0=write 1=read
//   cfg_addr, cfg_wdata   localbus address / write data
//   cfg_ack_n, cfg_rdata  localbus acknowledge (active-low) / read data
//   sent_start            high for the whole RUN state
//   sent_end              one-cycle pulse on entry to DRAIN
//   stat_reset            one-cycle pulse in CLEAR
//   protocol_type, n_rtt  PROTO / RTT latched when a run starts
//   stat_bit_cnt/pkt_cnt  counters from the statistics module (CNT_W <= 64)

module meas_sched #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int          CNT_W     = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_cs_n,
    input  logic             cfg_rw,
    input  logic [31:0]      cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic             cfg_ack_n,
    output logic [31:0]      cfg_rdata,
    output logic             sent_start,
    output logic             sent_end,
    output logic             stat_reset,
    output logic [7:0]       protocol_type,
    output logic [31:0]      n_rtt,
    input  logic [CNT_W-1:0] stat_bit_cnt,
    input  logic [CNT_W-1:0] stat_pkt_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_SNAP  = 3'd4;
    localparam logic [2:0] S_GAP   = 3'd5;

    logic [2:0]  state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ack_q;
    logic [31:0] rdata_q;
    logic [31:0] window_q, rtt_q;
    logic [7:0]  proto_q;
    logic [7:0]  proto_lat_q;
    logic [31:0] rtt_lat_q;
    logic        done_q, aborted_q;
    logic [15:0] run_cnt_q;
    logic [63:0] bits_q, pkts_q;
    logic        end_q;
    logic        periodic;
    logic [31:0] gap_val;

    // ---------------------------------------------------------------
    // Localbus decode: one access per cs_n assertion; ack_q blocks a
    // second access until cs_n has been released.
    // ---------------------------------------------------------------
    logic       acc, hit, wr, busy;
    logic [7:0] off;
    logic       ctrl_wr, abort_req, go_req, clr_req, snap_en, relatch;

    assign acc       = !cfg_cs_n && !ack_q;
    assign hit       = (cfg_addr[31:8] == ADDR_BASE[31:8]);
    assign off       = cfg_addr[7:0];
    assign wr        = acc && !cfg_rw && hit;
    assign busy      = (state_q != S_IDLE);
    assign ctrl_wr   = wr && (off == 8'h00);
    assign abort_req = ctrl_wr && cfg_wdata[1];
    // abort beats go when both are written together
    assign go_req    = ctrl_wr && cfg_wdata[0] && !cfg_wdata[1] && !busy;
    assign clr_req   = ctrl_wr && cfg_wdata[2];

`ifdef MEAS_SCHED_PERIODIC_EN
    logic        periodic_q;
    logic [31:0] gap_q;
    assign periodic = periodic_q;
    assign gap_val  = gap_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            periodic_q <= 1'b0;
            gap_q      <= '0;
        end else begin
            if (ctrl_wr)
                periodic_q <= cfg_wdata[3] && !cfg_wdata[1];
            if (wr && off == 8'h24 && !busy)
                gap_q <= cfg_wdata;
        end
    end
`else
    assign periodic = 1'b0;
    assign gap_val  = 32'd0;
`endif

    function automatic logic [31:0] max1(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

    // ---------------------------------------------------------------
    // Sequencer. cnt_q is loaded on entry to each timed state and the
    // state is left in the cycle where it reads 1.
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_en = 1'b0;
        relatch = 1'b0;
        case (state_q)
            S_IDLE: if (go_req) begin
                state_d = S_CLEAR;
                relatch = 1'b1;
            end
            S_CLEAR: begin
                state_d = S_RUN;
                cnt_d   = max1(window_q);
            end
            S_RUN: if (cnt_q == 32'd1) begin
                state_d = S_DRAIN;
                cnt_d   = max1(rtt_lat_q);
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
            S_DRAIN: if (cnt_q == 32'd1) begin
                state_d = S_SNAP;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
            S_SNAP: begin
                snap_en = 1'b1;
                if (periodic) begin
                    state_d = S_GAP;
                    cnt_d   = max1(gap_val);
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: if (cnt_q == 32'd1) begin
                state_d = S_CLEAR;
                relatch = 1'b1;
            end else begin
                cnt_d = cnt_q - 32'd1;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_req && busy) begin
            state_d = S_IDLE;
            snap_en = 1'b0;
            relatch = 1'b0;
        end
    end

    // Counter inputs narrower than 64 bits are zero-extended.
    logic [63:0] bit_ext, pkt_ext;
    always_comb begin
        bit_ext = '0;
        pkt_ext = '0;
        bit_ext[CNT_W-1:0] = stat_bit_cnt;
        pkt_ext[CNT_W-1:0] = stat_pkt_cnt;
    end

    logic [31:0] rd_mux;
    always_comb begin
        rd_mux = 32'd0;
        case (off)
            8'h00: rd_mux = {28'd0, periodic, 3'd0};
            8'h04: rd_mux = window_q;
            8'h08: rd_mux = rtt_q;
            8'h0C: rd_mux = {24'd0, proto_q};
            8'h10: rd_mux = {run_cnt_q, 9'd0, aborted_q, busy, done_q, 1'b0, state_q};
            8'h14: rd_mux = bits_q[31:0];
            8'h18: rd_mux = bits_q[63:32];
            8'h1C: rd_mux = pkts_q[31:0];
            8'h20: rd_mux = pkts_q[63:32];
            8'h24: rd_mux = gap_val;
            default: rd_mux = 32'd0;
        endcase
        if (!hit)
            rd_mux = 32'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            window_q    <= '0;
            rtt_q       <= '0;
            proto_q     <= '0;
            proto_lat_q <= '0;
            rtt_lat_q   <= '0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            run_cnt_q   <= '0;
            bits_q      <= '0;
            pkts_q      <= '0;
            end_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            end_q   <= (state_q == S_RUN) && (state_d == S_DRAIN);

            if (acc)
                ack_q <= 1'b1;
            else if (cfg_cs_n)
                ack_q <= 1'b0;
            if (acc && cfg_rw)
                rdata_q <= rd_mux;

            if (wr && !busy) begin
                if (off == 8'h04) window_q <= cfg_wdata;
                if (off == 8'h08) rtt_q    <= cfg_wdata;
                if (off == 8'h0C) proto_q  <= cfg_wdata[7:0];
            end

            if (relatch) begin
                proto_lat_q <= proto_q;
                rtt_lat_q   <= rtt_q;
            end

            if (go_req) begin
                done_q    <= 1'b0;
                aborted_q <= 1'b0;
            end
            if (clr_req)
                done_q <= 1'b0;
            if (abort_req && busy)
                aborted_q <= 1'b1;
            if (snap_en) begin
                done_q    <= 1'b1;
                run_cnt_q <= run_cnt_q + 16'd1;
                bits_q    <= bit_ext;
                pkts_q    <= pkt_ext;
            end
        end
    end

    assign cfg_ack_n     = !ack_q;
    assign cfg_rdata     = rdata_q;
    assign sent_start    = (state_q == S_RUN);
    assign stat_reset    = (state_q == S_CLEAR);
    assign sent_end      = end_q;
    assign protocol_type = proto_lat_q;
    assign n_rtt         = rtt_lat_q;

endmodule

// File: tb/tb_meas_sched.sv
// Scoreboard bench for meas_sched: bus reads push their expected value and
// a monitor compares on each read acknowledge; a run monitor measures
// sent_start lengths against queued expectations and counts pulses.
module tb_meas_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_cs_n = 1'b1;
    logic        cfg_rw = 1'b1;
    logic [31:0] cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic        cfg_ack_n;
    logic [31:0] cfg_rdata;
    logic        sent_start, sent_end, stat_reset;
    logic [7:0]  protocol_type;
    logic [31:0] n_rtt;
    logic [63:0] stat_bit_cnt = '0;
    logic [63:0] stat_pkt_cnt = '0;

    meas_sched dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_cs_n(cfg_cs_n), .cfg_rw(cfg_rw), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_ack_n(cfg_ack_n), .cfg_rdata(cfg_rdata),
        .sent_start(sent_start), .sent_end(sent_end), .stat_reset(stat_reset),
        .protocol_type(protocol_type), .n_rtt(n_rtt),
        .stat_bit_cnt(stat_bit_cnt), .stat_pkt_cnt(stat_pkt_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      run_q[$];
    int      sr_times[$];
    int      checks = 0, errors = 0;
    int      end_cnt = 0, sr_cnt = 0, exp_end = 0, exp_sr = 0;
    int      acc_edge = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // read-data monitor and run monitor, both sampled on the falling edge
    logic prev_ack = 1'b1;
    int   run_len = 0;
    always @(negedge clk) begin
        if (!cfg_ack_n && prev_ack && cfg_rw) begin
            if (rd_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_read: data 0x%0h with no expectation", cfg_rdata);
            end else begin
                rd_exp_t e;
                e = rd_q.pop_front();
                chk(e.name, {32'd0, cfg_rdata}, {32'd0, e.exp});
            end
        end
        prev_ack = cfg_ack_n;

        if (sent_start) begin
            run_len++;
        end else if (run_len > 0) begin
            if (run_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_run: length %0d, none expected", run_len);
            end else begin
                chk("run_length", run_len, run_q.pop_front());
            end
            run_len = 0;
        end
        if (sent_end) end_cnt++;
        if (stat_reset) begin
            sr_cnt++;
            sr_times.push_back(cyc);
        end
    end

    // Caller is 1ns after an edge with the bus idle; returns likewise.
    task automatic bus_acc(input logic r, input logic [7:0] off, input logic [31:0] d);
        int n;
        cfg_cs_n = 1'b0; cfg_rw = r; cfg_addr = {24'd0, off}; cfg_wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (cfg_ack_n && n < 8);
        if (cfg_ack_n) begin
            checks++; errors++;
            $display("FAIL bus_ack_timeout: ack_n=%0b, expected 0 at offset 0x%0h", cfg_ack_n, off);
        end
        acc_edge = cyc;
        cfg_cs_n = 1'b1;
        @(posedge clk); #1;
        if (!cfg_ack_n) begin
            checks++; errors++;
            $display("FAIL bus_ack_release: ack_n=%0b, expected 1", cfg_ack_n);
        end
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        bus_acc(1'b0, off, d);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string name);
        rd_exp_t e;
        e.name = name; e.exp = exp;
        rd_q.push_back(e);
        bus_acc(1'b1, off, 32'd0);
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_sent_start"}, sent_start, 0);
        chk({tag, "_sent_end"}, sent_end, 0);
        chk({tag, "_stat_reset"}, stat_reset, 0);
        chk({tag, "_protocol_type"}, protocol_type, 0);
        chk({tag, "_n_rtt"}, n_rtt, 0);
        chk({tag, "_ack_n"}, cfg_ack_n, 1);
        chk({tag, "_rdata"}, cfg_rdata, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // every register reads 0 out of reset
        for (int i = 0; i < 10; i++) rd(8'(i * 4), 32'd0, "reset_reg");
        rd(8'h40, 32'd0, "reset_unmapped");

        // ---- normal run: W=10, R=5, PROTO=6 ----
        stat_bit_cnt = 64'h1_0000_0040;
        stat_pkt_cnt = 64'h25;
        wr(8'h04, 32'd10);
        wr(8'h08, 32'd5);
        wr(8'h0C, 32'h06);
        rd(8'h04, 32'd10, "window_rb");
        run_q.push_back(10); exp_sr++; exp_end++;
        wr(8'h00, 32'h1);
        e = acc_edge;
        chk("protocol_type", protocol_type, 8'h06);
        chk("n_rtt", n_rtt, 32'd5);
        wait_until(e + 15);
        rd(8'h10, 32'h0000_0023, "status_last_drain");
        rd(8'h10, 32'h0001_0010, "status_done_run1");
        rd(8'h14, 32'h0000_0040, "bits_lo");
        rd(8'h18, 32'h0000_0001, "bits_hi");
        rd(8'h1C, 32'h0000_0025, "pkts_lo");
        rd(8'h20, 32'h0000_0000, "pkts_hi");

        // ---- zero window / zero rtt: 1-cycle RUN and DRAIN ----
        stat_bit_cnt = 64'h2_0000_0001;
        stat_pkt_cnt = 64'h7;
        wr(8'h04, 32'd0);
        wr(8'h08, 32'd0);
        run_q.push_back(1); exp_sr++; exp_end++;
        wr(8'h00, 32'h1);
        rd(8'h10, 32'h0001_0022, "status_run_w0");
        rd(8'h10, 32'h0001_0024, "status_snap_w0");
        rd(8'h10, 32'h0002_0010, "status_done_run2");
        rd(8'h14, 32'h0000_0001, "bits_lo_run2");
        rd(8'h18, 32'h0000_0002, "bits_hi_run2");

        // ---- abort 3 cycles into RUN ----
        wr(8'h04, 32'd20);
        wr(8'h08, 32'd5);
        stat_bit_cnt = 64'hDEAD_BEEF_0000_1111;
        stat_pkt_cnt = 64'h55;
        run_q.push_back(3); exp_sr++;
        wr(8'h00, 32'h1);
        e = acc_edge;
        wait_until(e + 3);
        wr(8'h00, 32'h2);
        rd(8'h10, 32'h0002_0040, "status_aborted");
        rd(8'h14, 32'h0000_0001, "bits_lo_after_abort");
        rd(8'h1C, 32'h0000_0007, "pkts_lo_after_abort");
        wr(8'h00, 32'h3);
        repeat (3) @(posedge clk);
        #1;
        rd(8'h10, 32'h0002_0040, "status_go_abort");

        // ---- write while busy, then reset mid-DRAIN ----
        wr(8'h04, 32'd30);
        run_q.push_back(30); exp_sr++; exp_end++;
        wr(8'h00, 32'h1);
        e = acc_edge;
        wr(8'h04, 32'd99);
        rd(8'h04, 32'd30, "window_busy_write");
        wait_until(e + 33);
        chk("n_rtt_before_reset", n_rtt, 32'd5);
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("mid_drain_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rd(8'h10, 32'd0, "status_after_reset");
        rd(8'h14, 32'd0, "bits_lo_after_reset");
        rd(8'h18, 32'd0, "bits_hi_after_reset");
        rd(8'h04, 32'd0, "window_after_reset");

`ifdef MEAS_SCHED_PERIODIC_EN
        // ---- periodic: W=2, R=1, GAP=4 ----
        wr(8'h04, 32'd2);
        wr(8'h08, 32'd1);
        wr(8'h24, 32'd4);
        rd(8'h24, 32'd4, "gap_rb");
        sr_times.delete();
        run_q.push_back(2); run_q.push_back(2);
        exp_sr += 2; exp_end += 2;
        wr(8'h00, 32'h9);
        e = acc_edge;
        rd(8'h00, 32'h8, "ctrl_periodic_rb");
        wait_until(e + 10);
        wr(8'h00, 32'h0);
        wait_until(e + 20);
        rd(8'h10, 32'h0002_0010, "status_periodic_end");
        chk("periodic_clear_count", sr_times.size(), 2);
        if (sr_times.size() >= 2)
            chk("periodic_clear_spacing", sr_times[1] - sr_times[0], 9);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("rd_queue_drained", rd_q.size(), 0);
        chk("run_queue_drained", run_q.size(), 0);
        chk("sent_end_pulses", end_cnt, exp_end);
        chk("stat_reset_pulses", sr_cnt, exp_sr);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
